vga_capture: RTL and testbench

- Receive end of the VGA interface: samples an incoming hsync/vsync/rgb stream produced by the display-side VGA timing generator, or by an external 640x480 source.
- Recovers the active-video window and emits a pixel stream tagged with x/y coordinates and frame/line markers.
- Feeds the Sobel front end, and is used to loop the display timing back for self-test.
- Sampling is qualified by a pixel-enable strobe, nominally one clk in four at a 100 MHz clk.

---
 rtl/vga_capture.sv | 179 +++++++++++++++++
 tb/tb_vga_capture.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_capture.sv
// Receive side of the VGA link: recovers the active window from hsync/vsync/rgb
// and emits a pixel stream tagged with x/y and sof/eol/eof markers.
module vga_capture #(
    parameter int CD = 8,
    parameter int HD = 640,
    parameter int HR = 96,
    parameter int HB = 48,
    parameter int VD = 480,
    parameter int VR = 2,
    parameter int VB = 33
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic          vga_hsync,
    input  logic          vga_vsync,
    input  logic [CD-1:0] vga_rgb,
    output logic          so_valid,
    output logic [CD-1:0] so_rgb,
    output logic [10:0]   so_x,
    output logic [10:0]   so_y,
    output logic          so_sof,
    output logic          so_eol,
    output logic          so_eof,
    output logic          locked,
    output logic          frame_err
);

    typedef enum logic [2:0] {
        IDLE,
        VBLANK,
        HPORCH,
        ACTIVE,
        HWAIT
    } state_t;

    // The hsync fall is retrace pixel 0, so the porch ends one count early.
    localparam logic [10:0] PORCH_LAST = 11'(HR + HB - 2);
    localparam logic [10:0] VBL_LAST   = 11'(VR + VB - 1);
    localparam logic [10:0] X_LAST     = 11'(HD - 1);
    localparam logic [10:0] Y_LAST     = 11'(VD - 1);

    state_t      state;
    logic        prev_hsync;
    logic        prev_vsync;
    logic [10:0] line_cnt;
    logic [10:0] px_cnt;
    logic [10:0] col;
    logic [10:0] row;
    logic        err_frame;
    logic        hs_fall;
    logic        vs_fall;

    assign hs_fall = prev_hsync & ~vga_hsync;
    assign vs_fall = prev_vsync & ~vga_vsync;

    // NOTE: the sync history resets high so a sync already low at reset release
    // is not taken as a fresh fall edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_hsync <= 1'b1;
            prev_vsync <= 1'b1;
        end else if (pix_en) begin
            prev_hsync <= vga_hsync;
            prev_vsync <= vga_vsync;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            line_cnt  <= '0;
            px_cnt    <= '0;
            col       <= '0;
            row       <= '0;
            err_frame <= 1'b0;
            so_valid  <= 1'b0;
            so_rgb    <= '0;
            so_x      <= '0;
            so_y      <= '0;
            so_sof    <= 1'b0;
            so_eol    <= 1'b0;
            so_eof    <= 1'b0;
            locked    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            // NOTE: markers are single-clk pulses, so they clear on every clk,
            // not only on pix_en clocks.
            so_valid <= 1'b0;
            so_sof   <= 1'b0;
            so_eol   <= 1'b0;
            so_eof   <= 1'b0;

            if (pix_en) begin
                if (vs_fall && state != IDLE) begin
                    // Truncated frame: this vsync fall starts a fresh frame.
                    frame_err <= 1'b1;
                    locked    <= 1'b0;
                    err_frame <= 1'b0;
                    line_cnt  <= '0;
                    state     <= VBLANK;
                end else if (hs_fall && (state == HPORCH || state == ACTIVE)) begin
                    frame_err <= 1'b1;
                    locked    <= 1'b0;
                    err_frame <= 1'b1;
                    px_cnt    <= '0;
                    // A short last row leaves no row to move on to: drop the frame.
                    if (row == Y_LAST) begin
                        state <= IDLE;
                    end else begin
                        row   <= row + 11'd1;
                        state <= HPORCH;
                    end
                end else begin
                    case (state)
                        IDLE: begin
                            if (vs_fall) begin
                                line_cnt  <= '0;
                                err_frame <= 1'b0;
                                state     <= VBLANK;
                            end
                        end

                        VBLANK: begin
                            if (hs_fall) begin
                                if (line_cnt == VBL_LAST) begin
                                    row    <= '0;
                                    px_cnt <= '0;
                                    state  <= HPORCH;
                                end else begin
                                    line_cnt <= line_cnt + 11'd1;
                                end
                            end
                        end

                        HPORCH: begin
                            px_cnt <= px_cnt + 11'd1;
                            if (px_cnt == PORCH_LAST) begin
                                col   <= '0;
                                state <= ACTIVE;
                            end
                        end

                        ACTIVE: begin
                            so_valid <= 1'b1;
                            so_rgb   <= vga_rgb;
                            so_x     <= col;
                            so_y     <= row;
                            so_sof   <= (col == '0) && (row == '0);
                            so_eol   <= (col == X_LAST);
                            so_eof   <= (col == X_LAST) && (row == Y_LAST);
                            col      <= col + 11'd1;
                            if (col == X_LAST) begin
                                col <= '0;
                                if (row == Y_LAST) begin
                                    locked <= ~err_frame;
                                    state  <= IDLE;
                                end else begin
                                    state <= HWAIT;
                                end
                            end
                        end

                        HWAIT: begin
                            if (hs_fall) begin
                                row    <= row + 11'd1;
                                px_cnt <= '0;
                                state  <= HPORCH;
                            end
                        end

                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture: a reduced-size timing generator drives the DUT while a
// coordinate-based model predicts every output on every clk.
module tb_vga_capture;

    localparam int CD = 8;
    localparam int HD = 16, HR = 4, HB = 3, HF = 5;
    localparam int VD = 6, VR = 2, VB = 3, VF = 2;
    localparam int HT = HR + HB + HD + HF;
    localparam int VT = VR + VB + VD + VF;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          pix_en    = 1'b0;
    logic          vga_hsync = 1'b1;
    logic          vga_vsync = 1'b1;
    logic [CD-1:0] vga_rgb   = '0;
    logic          so_valid;
    logic [CD-1:0] so_rgb;
    logic [10:0]   so_x;
    logic [10:0]   so_y;
    logic          so_sof;
    logic          so_eol;
    logic          so_eof;
    logic          locked;
    logic          frame_err;

    vga_capture #(
        .CD(CD), .HD(HD), .HR(HR), .HB(HB), .VD(VD), .VR(VR), .VB(VB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_en    (pix_en),
        .vga_hsync (vga_hsync),
        .vga_vsync (vga_vsync),
        .vga_rgb   (vga_rgb),
        .so_valid  (so_valid),
        .so_rgb    (so_rgb),
        .so_x      (so_x),
        .so_y      (so_y),
        .so_sof    (so_sof),
        .so_eol    (so_eol),
        .so_eof    (so_eof),
        .locked    (locked),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Generator position of the next sample, retrace-origin coordinates.
    int h = 0;
    int v = 0;

    // Model state and expected outputs.
    bit            synced = 1'b0;
    bit            clean  = 1'b0;
    logic          e_valid = 1'b0, e_sof = 1'b0, e_eol = 1'b0, e_eof = 1'b0;
    logic          e_locked = 1'b0, e_err = 1'b0;
    logic [10:0]   e_x = '0, e_y = '0;
    logic [CD-1:0] e_rgb = '0;

    int          n_valid = 0, n_sof = 0, n_eol = 0, n_eof = 0;
    bit          watch = 1'b0;
    logic [10:0] w_x = 11'h7ff, w_y = 11'h7ff;

    function automatic int ax(input int x);
        return HR + HB + x;
    endfunction

    function automatic int ay(input int y);
        return VR + VB + y;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic clear_pulses();
        e_valid = 1'b0;
        e_sof   = 1'b0;
        e_eol   = 1'b0;
        e_eof   = 1'b0;
    endtask

    task automatic reset_counts();
        n_valid = 0;
        n_sof   = 0;
        n_eol   = 0;
        n_eof   = 0;
    endtask

    // One clk without a sample; the inputs carry junk the DUT must ignore.
    task automatic idle_clk();
        @(negedge clk);
        pix_en    = 1'b0;
        vga_hsync = 1'($urandom);
        vga_vsync = 1'($urandom);
        vga_rgb   = CD'($urandom);
        @(posedge clk);
        clear_pulses();
    endtask

    // One generator pixel: a pix_en clk followed by three idle clks.
    task automatic sample(input bit inject);
        int            x;
        int            y;
        bit            act;
        logic [CD-1:0] rgb;
        x   = h - (HR + HB);
        y   = v - (VR + VB);
        act = (x >= 0) && (x < HD) && (y >= 0) && (y < VD);
        rgb = act ? CD'(x ^ y) : CD'($urandom);
        @(negedge clk);
        pix_en    = 1'b1;
        vga_hsync = (h >= HR);
        vga_vsync = (v >= VR);
        vga_rgb   = rgb;
        @(posedge clk);
        if (inject) begin
            e_locked = 1'b0;
            e_err    = 1'b1;
            clean    = 1'b0;
        end
        if (h == 0 && v == 0) begin
            synced = 1'b1;
            clean  = 1'b1;
        end
        clear_pulses();
        if (synced && act) begin
            e_valid = 1'b1;
            e_rgb   = rgb;
            e_x     = 11'(x);
            e_y     = 11'(y);
            e_sof   = (x == 0) && (y == 0);
            e_eol   = (x == HD - 1);
            e_eof   = e_eol && (y == VD - 1);
            if (e_eof) begin
                e_locked = clean;
                synced   = 1'b0;
            end
            if (e_sof) begin
                #1;
                check("sof_latency", 64'({so_valid, so_sof, so_x, so_y}),
                      64'({1'b1, 1'b1, 11'd0, 11'd0}));
            end
        end
        h++;
        if (h == HT) begin
            h = 0;
            v++;
            if (v == VT) v = 0;
        end
        repeat (3) idle_clk();
    endtask

    task automatic run_until(input int tv, input int th);
        while (!(v == tv && h == th)) sample(1'b0);
    endtask

    task automatic finish_frame();
        do sample(1'b0); while (!(h == 0 && v == 0));
    endtask

    task automatic check_counts(input string tag, input int ev, input int es, input int el, input int ef);
        check({tag, "_valid_count"}, 64'(n_valid), 64'(ev));
        check({tag, "_sof_count"},   64'(n_sof),   64'(es));
        check({tag, "_eol_count"},   64'(n_eol),   64'(el));
        check({tag, "_eof_count"},   64'(n_eof),   64'(ef));
    endtask

    task automatic check_flags(input string tag, input logic el, input logic ee);
        #1;
        check({tag, "_locked"},    64'(locked),    64'(el));
        check({tag, "_frame_err"}, 64'(frame_err), 64'(ee));
    endtask

    // Compare process: every output, every clk.
    always @(negedge clk) begin
        check("stream",
              64'({so_valid, so_sof, so_eol, so_eof, locked, frame_err, so_x, so_y, so_rgb}),
              64'({e_valid, e_sof, e_eol, e_eof, e_locked, e_err, e_x, e_y, e_rgb}));
        if (so_valid) n_valid++;
        if (so_valid && so_sof) n_sof++;
        if (so_valid && so_eol) n_eol++;
        if (so_valid && so_eof) n_eof++;
        if (watch && so_valid) begin
            w_x   = so_x;
            w_y   = so_y;
            watch = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              64'({so_valid, so_sof, so_eol, so_eof, locked, frame_err, so_x, so_y, so_rgb}), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Frame A: clean frame from the vsync fall.
        reset_counts();
        finish_frame();
        check_counts("frame_a", HD * VD, 1, VD, 1);
        check_flags("frame_a", 1'b1, 1'b0);

        // Frame B: pix_en withheld for 1000 clk in mid-line.
        reset_counts();
        run_until(ay(2), ax(7));
        repeat (1000) idle_clk();
        finish_frame();
        check_counts("frame_b", HD * VD, 1, VD, 1);
        check_flags("frame_b", 1'b1, 1'b0);

        // Frame C: row 3 cut short by an hsync fall at x=9.
        reset_counts();
        run_until(ay(3), ax(9));
        h = 0;
        v = v + 1;
        sample(1'b1);
        check_flags("short_line", 1'b0, 1'b1);
        watch = 1'b1;
        finish_frame();
        check("short_next_x", 64'(w_x), 64'(0));
        check("short_next_y", 64'(w_y), 64'(4));
        check_counts("frame_c", HD * VD - (HD - 9), 1, VD - 1, 1);
        check_flags("frame_c", 1'b0, 1'b1);

        // Frame D truncated by a vsync fall at row 4, then clean frame E.
        reset_counts();
        run_until(ay(4), ax(5));
        h = 0;
        v = 0;
        sample(1'b1);
        finish_frame();
        check_counts("frames_d_e", 4 * HD + 5 + HD * VD, 2, 4 + VD, 1);
        check_flags("frame_e", 1'b1, 1'b1);

        // Frame F: asynchronous reset during row 2, then clean frame G.
        run_until(ay(2), ax(3));
        @(posedge clk);
        #3 reset = 1'b0;
        clear_pulses();
        e_locked = 1'b0;
        e_err    = 1'b0;
        e_x      = '0;
        e_y      = '0;
        e_rgb    = '0;
        synced   = 1'b0;
        clean    = 1'b0;
        #1;
        check("async_reset",
              64'({so_valid, so_sof, so_eol, so_eof, locked, frame_err, so_x, so_y, so_rgb}), 64'(0));
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        reset_counts();
        finish_frame();
        check("after_reset_valid_count", 64'(n_valid), 64'(0));
        reset_counts();
        finish_frame();
        check_counts("frame_g", HD * VD, 1, VD, 1);
        check_flags("frame_g", 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
